// File: rtl/serial_word_rx.sv
// MSB-first serial-to-parallel word receiver with ready/valid delivery and a sticky overrun flag.
// Defining PARITY_CHECK_EN adds a trailing even-parity bit per frame and the parity_err output.
module serial_word_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             inv,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
`ifdef PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             inv_q, inv_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
`ifdef PARITY_CHECK_EN
    logic             perr_q, perr_d;
    logic             perr_new;
`endif

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic             word_done;

    assign shifted = {sreg_q[WIDTH-2:0], sin};

    // NOTE: every variable gets its hold value first so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        inv_d       = inv_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        word_done   = 1'b0;
        word        = '0;
`ifdef PARITY_CHECK_EN
        perr_d      = perr_q;
        perr_new    = 1'b0;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    inv_d   = inv;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    sreg_d = shifted;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d   = IDLE;
                        word_done = 1'b1;
                        word      = inv_q ? ~shifted : shifted;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                // Parity covers the bits as they arrived on the wire, before any un-inversion.
                if (sin_valid) begin
                    state_d   = IDLE;
                    word_done = 1'b1;
                    word      = inv_q ? ~sreg_q : sreg_q;
                    perr_new  = (^sreg_q) ^ sin;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A finished word loads only into a free (or simultaneously drained) output slot.
        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = word;
                out_valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                perr_d      = perr_new;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            inv_q       <= inv_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
`ifdef PARITY_CHECK_EN
            perr_q      <= perr_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);
`ifdef PARITY_CHECK_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench for serial_word_rx: a frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic. Honours PARITY_CHECK_EN.
module tb_serial_word_rx;

    localparam int WIDTH = 4;
`ifdef PARITY_CHECK_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             inv;
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
`ifdef PARITY_CHECK_EN
    logic             parity_err;
    logic             par_flip = 1'b0;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    serial_word_rx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .inv       (inv),
        .sin       (sin),
        .sin_valid (sin_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a frame is the list of valid bits seen after start; the word is rebuilt from it.
    bit               m_busy = 1'b0;
    bit               m_inv  = 1'b0;
    bit               m_bits[$];
    bit               m_outv = 1'b0;
    logic [WIDTH-1:0] m_outd = '0;
    bit               m_ovr  = 1'b0;
    bit               m_perr = 1'b0;

    always @(posedge clk) begin : model
        logic [WIDTH-1:0] w;
        bit               done;
        bit               pe;
        bit               accept;
        done   = 1'b0;
        pe     = 1'b0;
        w      = '0;
        accept = m_outv && out_ready;
        if (!reset) begin
            m_busy = 1'b0;
            m_inv  = 1'b0;
            m_bits.delete();
            m_outv = 1'b0;
            m_outd = '0;
            m_ovr  = 1'b0;
            m_perr = 1'b0;
        end else begin
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    m_inv  = inv;
                    m_bits.delete();
                end
            end else if (sin_valid) begin
                m_bits.push_back(sin);
                if (m_bits.size() == FRAME) begin
                    done = 1'b1;
                    for (int i = 0; i < WIDTH; i++) w = (w << 1) | WIDTH'(m_bits[i]);
                    if (FRAME > WIDTH) pe = ((^w) != m_bits[FRAME-1]);
                    if (m_inv) w = ~w;
                    m_busy = 1'b0;
                end
            end
            if (done) begin
                if (!m_outv || out_ready) begin
                    m_outd = w;
                    m_outv = 1'b1;
                    m_perr = pe;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (accept) begin
                m_outv = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out_valid", 32'(out_valid), 32'(m_outv));
            check("model_busy",      32'(busy),      32'(m_busy));
            check("model_overrun",   32'(overrun),   32'(m_ovr));
            if (m_outv) check("model_out_data", 32'(out_data), 32'(m_outd));
`ifdef PARITY_CHECK_EN
            check("model_parity_err", 32'(parity_err), 32'(m_perr));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // raw = bits as they appear on the wire, MSB first; a junk bit rides the start cycle.
    task automatic send_frame(input logic [WIDTH-1:0] raw, input logic inv_b, input int gap);
        start     = 1'b1;
        inv       = inv_b;
        sin       = 1'b1;
        sin_valid = 1'b1;
        step();
        start = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            sin_valid = 1'b0;
            repeat (gap) step();
            sin       = raw[i];
            sin_valid = 1'b1;
            step();
        end
`ifdef PARITY_CHECK_EN
        sin       = (^raw) ^ par_flip;
        sin_valid = 1'b1;
        step();
`endif
        sin_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        inv       = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        out_ready = 1'b0;

        // Reset with sin_valid toggling.
        step();
        sin_valid = 1'b1;
        step();
        chk_en = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_overrun",   32'(overrun),   32'd0);
        sin_valid = 1'b0;
        reset     = 1'b1;
        step();

        // Plain frame 1011, consumer ready.
        out_ready = 1'b1;
        send_frame(4'b1011, 1'b0, 0);
        check("f1_valid", 32'(out_valid), 32'd1);
        check("f1_data",  32'(out_data),  32'hB);
        check("f1_busy",  32'(busy),      32'd0);
        step();
        check("f1_drained", 32'(out_valid), 32'd0);

        // Inverted stream 0101 with two idle cycles between bits.
        send_frame(4'b0101, 1'b1, 2);
        check("f2_data", 32'(out_data), 32'hA);
        step();

        // Held word then overrun.
        out_ready = 1'b0;
        send_frame(4'b0110, 1'b0, 0);
        check("f3_data", 32'(out_data), 32'h6);
        send_frame(4'b1001, 1'b0, 0);
        check("ovr_data_kept", 32'(out_data),  32'h6);
        check("ovr_flag",      32'(overrun),   32'd1);
        check("ovr_valid",     32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        check("ovr_accepted", 32'(out_valid), 32'd0);
        check("ovr_sticky",   32'(overrun),   32'd1);

        // Reset mid-frame, then a clean frame.
        start     = 1'b1;
        step();
        start     = 1'b0;
        sin       = 1'b1;
        sin_valid = 1'b1;
        step();
        step();
        reset     = 1'b0;
        sin_valid = 1'b0;
        step();
        reset = 1'b1;
        check("mid_rst_busy",    32'(busy),      32'd0);
        check("mid_rst_valid",   32'(out_valid), 32'd0);
        check("mid_rst_overrun", 32'(overrun),   32'd0);
        send_frame(4'b1100, 1'b0, 0);
        check("post_rst_data",  32'(out_data),  32'hC);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        step();

`ifdef PARITY_CHECK_EN
        send_frame(4'b1110, 1'b0, 0);
        check("par_ok", 32'(parity_err), 32'd0);
        step();
        par_flip = 1'b1;
        send_frame(4'b1110, 1'b0, 0);
        check("par_bad", 32'(parity_err), 32'd1);
        par_flip = 1'b0;
        step();
`endif

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 3) == 0);
            inv       = 1'($urandom_range(0, 1));
            sin       = 1'($urandom_range(0, 1));
            sin_valid = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        reset     = 1'b1;
        start     = 1'b0;
        sin_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
